// File: rtl/bram_wave_player.sv
//------------------------------------------------------------------------------
// Module   : bram_wave_player
// Brief    : Plays an address window of a waveform BRAM at a decimated rate.
//            Supports single, continuous and N-repeat play modes.
//            Optional macro BRAM_OUT_REG_EN selects a 2-cycle BRAM read latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bram_wave_player #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int REP_WIDTH  = 16
) (
  input  logic                  axi_clock,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] cfg_start_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_last_addr,
  input  logic [31:0]           cfg_dec_rate,
  input  logic [1:0]            cfg_mode,
  input  logic [REP_WIDTH-1:0]  cfg_repeat,
  input  logic [DATA_WIDTH-1:0] cfg_default,
  input  logic                  trig,
  input  logic                  stop,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [DATA_WIDTH-1:0] bram_data_i,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic                  busy,
  output logic                  finish,
  output logic [REP_WIDTH-1:0]  loop_count
);

`ifdef BRAM_OUT_REG_EN
  localparam int c_pipe_depth = 3;
`else
  localparam int c_pipe_depth = 2;
`endif
  localparam logic [1:0]            c_drain_last = 2'(c_pipe_depth);
  localparam logic [ADDR_WIDTH-1:0] c_addr_one   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [REP_WIDTH-1:0]  c_rep_one    = {{(REP_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  logic                    r_trig_q;
  logic [ADDR_WIDTH-1:0]   r_start_addr;
  logic [ADDR_WIDTH-1:0]   r_last_addr;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [31:0]             r_dec_last;
  logic [31:0]             r_hold;
  logic [1:0]              r_mode;
  logic [REP_WIDTH-1:0]    r_repeat;
  logic [DATA_WIDTH-1:0]   r_default;
  logic [c_pipe_depth-1:0] r_vpipe;
  logic [c_pipe_depth-1:0] r_apipe;
  logic [1:0]              r_drain_cnt;

  logic                    w_start;
  logic                    w_abort;
  logic                    w_issue;
  logic                    w_expire;
  logic                    w_pass_end;
  logic                    w_again;
  logic [REP_WIDTH-1:0]    w_loop_next;

  assign w_start     = trig & ~r_trig_q & (r_state == IDLE) & ~stop;
  assign w_abort     = stop & (r_state != IDLE);
  assign w_issue     = (r_state == RUN) && (r_hold == 32'd0);
  assign w_expire    = (r_hold == r_dec_last);
  assign w_pass_end  = w_expire && (r_addr == r_last_addr);
  assign w_loop_next = loop_count + c_rep_one;
  // Continuous loops forever; N-repeat loops until the requested passes are done.
  assign w_again     = (r_mode == 2'b01) || ((r_mode == 2'b10) && (w_loop_next < r_repeat));

  always_ff @(posedge axi_clock or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_trig_q     <= 1'b0;
      r_start_addr <= '0;
      r_last_addr  <= '0;
      r_addr       <= '0;
      r_dec_last   <= '0;
      r_hold       <= '0;
      r_mode       <= '0;
      r_repeat     <= '0;
      r_default    <= '0;
      r_vpipe      <= '0;
      r_apipe      <= '0;
      r_drain_cnt  <= '0;
      bram_addr    <= '0;
      bram_en      <= 1'b0;
      dout         <= '0;
      dout_valid   <= 1'b0;
      busy         <= 1'b0;
      finish       <= 1'b0;
      loop_count   <= '0;
    end else begin
      r_trig_q   <= trig;
      finish     <= 1'b0;
      dout_valid <= 1'b0;
      if (w_abort) begin
        r_state <= IDLE;
        bram_en <= 1'b0;
        busy    <= 1'b0;
        dout    <= cfg_default;
        r_vpipe <= '0;
        r_apipe <= '0;
      end else begin
        // vpipe marks the first cycle of each address, apipe any played cycle.
        r_vpipe    <= {r_vpipe[c_pipe_depth-2:0], w_issue};
        r_apipe    <= {r_apipe[c_pipe_depth-2:0], (r_state == RUN)};
        dout_valid <= r_vpipe[c_pipe_depth-1];
        if (r_vpipe[c_pipe_depth-1])
          dout <= bram_data_i;
        else if (!r_apipe[c_pipe_depth-1])
          dout <= (r_state == IDLE) ? cfg_default : r_default;

        case (r_state)
          IDLE: begin
            bram_en <= 1'b0;
            if (w_start) begin
              r_start_addr <= cfg_start_addr;
              r_last_addr  <= cfg_last_addr;
              r_dec_last   <= (cfg_dec_rate == 32'd0) ? 32'd0 : cfg_dec_rate - 32'd1;
              r_mode       <= cfg_mode;
              r_repeat     <= (cfg_repeat == '0) ? c_rep_one : cfg_repeat;
              r_default    <= cfg_default;
              r_addr       <= cfg_start_addr;
              r_hold       <= '0;
              loop_count   <= '0;
              busy         <= 1'b1;
              r_state      <= RUN;
            end
          end
          RUN: begin
            bram_en   <= 1'b1;
            bram_addr <= r_addr;
            if (w_expire) begin
              r_hold <= '0;
              if (w_pass_end) begin
                if ((r_mode != 2'b01) || (loop_count != '1))
                  loop_count <= w_loop_next;
                r_addr <= r_start_addr;
                if (!w_again) begin
                  r_drain_cnt <= '0;
                  r_state     <= DRAIN;
                end
              end else begin
                r_addr <= r_addr + c_addr_one;
              end
            end else begin
              r_hold <= r_hold + 32'd1;
            end
          end
          DRAIN: begin
            bram_en <= 1'b0;
            if (r_drain_cnt == c_drain_last) begin
              finish  <= 1'b1;
              busy    <= 1'b0;
              r_state <= IDLE;
            end else begin
              r_drain_cnt <= r_drain_cnt + 2'd1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bram_wave_player.sv
//------------------------------------------------------------------------------
// Module   : tb_bram_wave_player
// Brief    : Directed self-checking bench for bram_wave_player (mem[i] = 0x1000+i).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bram_wave_player;

  localparam int AW = 10;
  localparam int DW = 32;
  localparam int RW = 16;
`ifdef BRAM_OUT_REG_EN
  localparam int P = 4;
`else
  localparam int P = 3;
`endif
  localparam logic [DW-1:0] DEF = 32'hDEAD_BEEF;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] cfg_start_addr;
  logic [AW-1:0] cfg_last_addr;
  logic [31:0]   cfg_dec_rate;
  logic [1:0]    cfg_mode;
  logic [RW-1:0] cfg_repeat;
  logic [DW-1:0] cfg_default;
  logic          trig;
  logic          stop;
  logic [AW-1:0] bram_addr;
  logic          bram_en;
  logic [DW-1:0] bram_data;
  logic [DW-1:0] dout;
  logic          dout_valid;
  logic          busy;
  logic          finish;
  logic [RW-1:0] loop_count;

  always #5 clk = ~clk;

  bram_wave_player #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REP_WIDTH(RW)) dut (
    .axi_clock      (clk),
    .rst            (rst),
    .cfg_start_addr (cfg_start_addr),
    .cfg_last_addr  (cfg_last_addr),
    .cfg_dec_rate   (cfg_dec_rate),
    .cfg_mode       (cfg_mode),
    .cfg_repeat     (cfg_repeat),
    .cfg_default    (cfg_default),
    .trig           (trig),
    .stop           (stop),
    .bram_addr      (bram_addr),
    .bram_en        (bram_en),
    .bram_data_i    (bram_data),
    .dout           (dout),
    .dout_valid     (dout_valid),
    .busy           (busy),
    .finish         (finish),
    .loop_count     (loop_count)
  );

  // BRAM model: registered read, optional output register
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] q1 = '0;
  logic [DW-1:0] q2 = '0;
  always @(posedge clk) begin
    if (bram_en) q1 <= mem[bram_addr];
    q2 <= q1;
  end
`ifdef BRAM_OUT_REG_EN
  assign bram_data = q2;
`else
  assign bram_data = q1;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_fin;
  int n_val;

  logic [DW-1:0] cap_dout [0:39];
  logic          cap_val  [0:39];
  logic          cap_busy [0:39];
  logic          cap_fin  [0:39];
  logic          cap_en   [0:39];
  logic [AW-1:0] cap_addr [0:39];
  logic [RW-1:0] cap_loop [0:39];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setup(input logic [AW-1:0] s, input logic [AW-1:0] l, input logic [31:0] d,
                       input logic [1:0] m, input logic [RW-1:0] r);
    cfg_start_addr = s;
    cfg_last_addr  = l;
    cfg_dec_rate   = d;
    cfg_mode       = m;
    cfg_repeat     = r;
  endtask

  // Pulse trig so edge E0 samples it; cap_*[k] holds outputs just after E_k.
  task automatic play(input int n, input int retrig_k, input int stop_k, input bit scramble);
    @(negedge clk);
    trig  = 1'b1;
    n_fin = 0;
    n_val = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      cap_dout[k] = dout;
      cap_val[k]  = dout_valid;
      cap_busy[k] = busy;
      cap_fin[k]  = finish;
      cap_en[k]   = bram_en;
      cap_addr[k] = bram_addr;
      cap_loop[k] = loop_count;
      n_fin += int'(finish);
      n_val += int'(dout_valid);
      if (k == 0) trig = 1'b0;
      if (k == retrig_k) trig = 1'b1;
      if (k == retrig_k + 2) trig = 1'b0;
      if (k == stop_k) stop = 1'b1;
      if (k == stop_k + 1) stop = 1'b0;
      if (scramble && k == 1) setup(10'h100, 10'h100, 32'd5, 2'b01, 16'd9);
    end
    trig = 1'b0;
    stop = 1'b0;
    repeat (3) @(posedge clk);
  endtask

  initial begin
    for (int i = 0; i < (1 << AW); i++) mem[i] = 32'h1000 + i;
    rst         = 1'b1;
    trig        = 1'b0;
    stop        = 1'b0;
    cfg_default = DEF;
    setup(10'd0, 10'd0, 32'd1, 2'b00, 16'd1);

    repeat (3) @(posedge clk);
    #1;
    check_val("rst_dout", dout, 32'h0);
    check_val("rst_busy", 32'(busy), 32'd0);
    check_val("rst_en", 32'(bram_en), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_val("idle_dout", dout, DEF);

    // Single mode, 4..7, dec 1, config scrambled after start
    setup(10'd4, 10'd7, 32'd1, 2'b00, 16'd1);
    play(P + 6, -1, -1, 1'b1);
    check_val("s1_addr1", 32'(cap_addr[1]), 32'd4);
    check_val("s1_en1", 32'(cap_en[1]), 32'd1);
    check_val("s1_busy1", 32'(cap_busy[1]), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check_val($sformatf("s1_dout%0d", i), cap_dout[P+i], 32'h1004 + i);
      check_val($sformatf("s1_val%0d", i), 32'(cap_val[P+i]), 32'd1);
    end
    check_val("s1_dout_end", cap_dout[P+4], DEF);
    check_val("s1_fin", 32'(cap_fin[P+4]), 32'd1);
    check_val("s1_fin_after", 32'(cap_fin[P+5]), 32'd0);
    check_val("s1_busy_end", 32'(cap_busy[P+5]), 32'd0);
    check_val("s1_en_end", 32'(cap_en[P+5]), 32'd0);
    check_val("s1_nfin", n_fin, 32'd1);
    check_val("s1_loop", 32'(cap_loop[P+5]), 32'd1);

    // Decimation 3, window 0..1
    setup(10'd0, 10'd1, 32'd3, 2'b00, 16'd1);
    play(P + 8, -1, -1, 1'b0);
    check_val("s2_nval", n_val, 32'd2);
    check_val("s2_val0", 32'(cap_val[P]), 32'd1);
    check_val("s2_val1", 32'(cap_val[P+3]), 32'd1);
    check_val("s2_hold0", cap_dout[P+2], 32'h1000);
    check_val("s2_hold1", cap_dout[P+5], 32'h1001);
    check_val("s2_fin", 32'(cap_fin[P+6]), 32'd1);
    check_val("s2_dout_end", cap_dout[P+6], DEF);

    // Decimation 0 behaves as 1
    setup(10'd0, 10'd1, 32'd0, 2'b00, 16'd1);
    play(P + 4, -1, -1, 1'b0);
    check_val("s2b_dout0", cap_dout[P], 32'h1000);
    check_val("s2b_dout1", cap_dout[P+1], 32'h1001);
    check_val("s2b_fin", 32'(cap_fin[P+2]), 32'd1);
    check_val("s2b_nval", n_val, 32'd2);

    // N-repeat, 3 passes over 2..3
    setup(10'd2, 10'd3, 32'd1, 2'b10, 16'd3);
    play(P + 9, -1, -1, 1'b0);
    for (int i = 0; i < 6; i++)
      check_val($sformatf("s3_dout%0d", i), cap_dout[P+i], 32'h1002 + (i % 2));
    check_val("s3_loop_a", 32'(cap_loop[2]), 32'd1);
    check_val("s3_loop_b", 32'(cap_loop[4]), 32'd2);
    check_val("s3_loop_c", 32'(cap_loop[6]), 32'd3);
    check_val("s3_fin", 32'(cap_fin[P+6]), 32'd1);
    check_val("s3_nfin", n_fin, 32'd1);
    check_val("s3_loop_end", 32'(cap_loop[P+8]), 32'd3);

    // N-repeat with repeat 0 gives one pass
    setup(10'd2, 10'd3, 32'd1, 2'b10, 16'd0);
    play(P + 5, -1, -1, 1'b0);
    check_val("s3b_dout0", cap_dout[P], 32'h1002);
    check_val("s3b_dout1", cap_dout[P+1], 32'h1003);
    check_val("s3b_fin", 32'(cap_fin[P+2]), 32'd1);
    check_val("s3b_nfin", n_fin, 32'd1);
    check_val("s3b_loop", 32'(cap_loop[P+3]), 32'd1);

    // Wrapping window 3FE..001
    setup(10'h3FE, 10'h001, 32'd1, 2'b00, 16'd1);
    play(P + 6, -1, -1, 1'b0);
    check_val("s4_addr0", 32'(cap_addr[1]), 32'h3FE);
    check_val("s4_addr1", 32'(cap_addr[2]), 32'h3FF);
    check_val("s4_addr2", 32'(cap_addr[3]), 32'h000);
    check_val("s4_addr3", 32'(cap_addr[4]), 32'h001);
    check_val("s4_dout2", cap_dout[P+2], 32'h1000);
    check_val("s4_fin", 32'(cap_fin[P+4]), 32'd1);

    // Continuous 4..8, retrig ignored, stop during sample 5
    setup(10'd4, 10'd8, 32'd1, 2'b01, 16'd1);
    play(P + 10, 2, P + 4, 1'b0);
    for (int i = 0; i < 5; i++)
      check_val($sformatf("s5_dout%0d", i), cap_dout[P+i], 32'h1004 + i);
    check_val("s5_stop_dout", cap_dout[P+5], DEF);
    check_val("s5_stop_busy", 32'(cap_busy[P+5]), 32'd0);
    check_val("s5_stop_en", 32'(cap_en[P+5]), 32'd0);
    check_val("s5_stop_val", 32'(cap_val[P+5]), 32'd0);
    check_val("s5_nfin", n_fin, 32'd0);
    check_val("s5_loop", 32'(cap_loop[P+9]), 32'd1);
    check_val("s5_idle_dout", cap_dout[P+9], DEF);

    // Continuous again, asynchronous reset mid-play
    setup(10'd4, 10'd8, 32'd1, 2'b01, 16'd1);
    play(8, -1, -1, 1'b0);
    check_val("s6_loop_clr", 32'(cap_loop[1]), 32'd0);
    check_val("s6_busy", 32'(cap_busy[7]), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check_val("s6_rst_dout", dout, 32'h0);
    check_val("s6_rst_busy", 32'(busy), 32'd0);
    check_val("s6_rst_en", 32'(bram_en), 32'd0);
    check_val("s6_rst_addr", 32'(bram_addr), 32'd0);
    check_val("s6_rst_loop", 32'(loop_count), 32'd0);
    check_val("s6_rst_val", 32'(dout_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_val("s6_post_dout", dout, DEF);
    check_val("s6_post_busy", 32'(busy), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bram_wave_player.md
Name: bram_wave_player

Overview:
- Parametrised successor to the single/continuous BRAM reader in the signal generator.
- Plays a programmable address window of a waveform BRAM through a registered output at a decimated sample rate.
- Three play modes: single, continuous, N-repeat.
- Sits between the AXI-lite BRAM read port and the DAC datapath; config comes from the register bank.

Parameters:
- ADDR_WIDTH, 10, BRAM address width (depth = 2^ADDR_WIDTH).
- DATA_WIDTH, 32, sample width.
- REP_WIDTH, 16, width of repeat count and loop counter.

Ports:
- axi_clock  in  1  single clock for all logic.
- rst  in  1  asynchronous, active-high reset.
- cfg_start_addr  in  ADDR_WIDTH  first address of window.
- cfg_last_addr  in  ADDR_WIDTH  last address of window (inclusive).
- cfg_dec_rate  in  32  clocks each sample is held; 0 treated as 1.
- cfg_mode  in  2  00 single, 01 continuous, 10 N-repeat, 11 treated as single.
- cfg_repeat  in  REP_WIDTH  passes in N-repeat mode; 0 treated as 1.
- cfg_default  in  DATA_WIDTH  dout value while idle.
- trig  in  1  start, rising-edge detected.
- stop  in  1  level, synchronous abort.
- bram_addr  out  ADDR_WIDTH  BRAM read address.
- bram_en  out  1  BRAM read enable.
- bram_data_i  in  DATA_WIDTH  BRAM read data, 1-cycle latency.
- dout  out  DATA_WIDTH  registered sample output.
- dout_valid  out  1  one-cycle pulse when dout takes a new BRAM sample.
- busy  out  1  high from start until finish or abort.
- finish  out  1  one-cycle pulse at natural end of play.
- loop_count  out  REP_WIDTH  completed passes since last start.

Behaviour:
- Reset values, applied asynchronously, including mid-play: all outputs 0; state IDLE; trig edge register 0.
- After reset release, dout follows cfg_default in IDLE, registered with 1-cycle lag.
- Edge detect: trig_q registered each cycle; start = trig & ~trig_q & (state==IDLE). Trig edges during RUN or DRAIN are ignored.
- On start, latch all cfg_* into shadow registers. Config changes mid-play have no effect.
- On start, clear loop_count and set busy the next cycle.
- States:
  - IDLE: bram_en=0, dout<=cfg_default. start -> RUN.
  - RUN: bram_en=1; bram_addr begins at start_addr; a hold counter counts dec_rate cycles per address; on expiry bram_addr advances by 1.
  - Address arithmetic is modulo 2^ADDR_WIDTH. If last<start, the window wraps through the top of memory, e.g. start=0x3FE, last=0x001 gives 4 samples.
  - At expiry on last_addr, the pass ends and loop_count increments. In continuous mode loop_count saturates at all-ones.
  - Pass-end transitions: single -> DRAIN; N-repeat with loop_count+1 < repeat -> RUN from start_addr with no gap cycle; continuous -> RUN from start_addr with no gap cycle.
  - DRAIN: bram_en=0; wait pipeline depth (2 cycles, 3 with the optional feature), then finish=1 for one cycle, busy=0, -> IDLE.
- Timing:
  - Trig edge sampled at edge E0; bram_addr=start valid after E1.
  - dout=mem[start] after E3, with dout_valid high for that cycle only.
  - Each sample stays on dout exactly dec_rate cycles. Output is gapless across addresses and passes.
  - After the final sample's dec_rate cycles, dout=cfg_default on the same cycle finish is asserted.
- stop high in RUN or DRAIN: next edge -> IDLE; bram_en=0, busy=0, dout=cfg_default. No finish pulse; loop_count holds its value. stop in IDLE has no effect. stop has priority over a same-cycle start.
- A single-address window (start==last) is legal.

Optional Feature:
- Macro: BRAM_OUT_REG_EN.
- Defined: the BRAM output register is assumed enabled (2-cycle read latency). The internal valid/data pipeline gets one extra stage, first sample appears after E4, and DRAIN waits 3 cycles. Hold timing and gaplessness are unchanged.
- Undefined: 1-cycle BRAM latency, as specified above.

Test Plan:
- Single mode, start=4, last=7, dec=1, mem[i]=i: pulse trig -> dout 4,5,6,7 on consecutive cycles from E3, then cfg_default with finish pulse on the following cycle; busy high over E1..finish.
- dec=3, start=0, last=1: each sample held 3 cycles; dout_valid pulses exactly twice, 3 cycles apart; dec=0 behaves identically to dec=1.
- N-repeat, repeat=3, window 2 samples: 6 samples gapless, loop_count 1,2,3, single finish; repeat=0 gives 1 pass.
- Wrap window start=0x3FE, last=0x001 (ADDR_WIDTH=10): bram_addr sequence 3FE,3FF,000,001.
- Continuous mode, trig retoggled mid-play (ignored), stop asserted at sample 5 -> dout=cfg_default next cycle, no finish, busy=0; repeat with rst asserted mid-play -> all outputs 0 immediately.
- BRAM_OUT_REG_EN defined: first sample at E4, sample values and hold timing otherwise identical to scenario 1.
